// File: rtl/led_pattern_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_pkg
//  Description : Shared types and helpers for the LED pattern generator.
//                mode_t enumerates the four animation patterns in the order
//                a mode press steps through them. cnt_width() sizes a counter
//                that must hold the values 0..n-1.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_ALT    = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_t;

    // Bits needed to count 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_pattern_gen_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Two-flop synchroniser followed by a debouncer. The settled
//                level only follows the synchronised input after it has
//                disagreed with the settled level for DB_CYCLES consecutive
//                clocks; shorter glitches are discarded.
//  Ports       : clk    - system clock
//                rst_n  - asynchronous active-low reset
//                din    - raw asynchronous input
//                level  - debounced level (reset 0)
//                rise   - high in the cycle whose closing edge moves level 0->1
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
    import led_pattern_pkg::*;
#(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int                  c_db_w    = cnt_width(DB_CYCLES);
    localparam logic [c_db_w-1:0]   c_db_last = c_db_w'(DB_CYCLES - 1);

    logic              r_s1;
    logic              r_s2;
    logic              r_db;
    logic [c_db_w-1:0] r_dcnt;
    logic              w_settle;

    // The input has disagreed long enough; the next edge adopts it.
    assign w_settle = (r_s2 != r_db) && (r_dcnt == c_db_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_db   <= 1'b0;
            r_dcnt <= '0;
        end else begin
            r_s1 <= din;
            r_s2 <= r_s1;
            if (r_s2 == r_db) begin
                r_dcnt <= '0;
            end else if (w_settle) begin
                r_db   <= r_s2;
                r_dcnt <= '0;
            end else begin
                r_dcnt <= r_dcnt + 1'b1;
            end
        end
    end

    assign level = r_db;
    // Decoded from registered state only, so it lines up with the edge that
    // updates level and carries no combinational path from din.
    assign rise  = w_settle & r_s2;

endmodule
`default_nettype wire

// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_gen
//  Description : Drives NUM_LEDS LEDs with one of four animations (ALT, CHASE,
//                BOUNCE, COUNT) advanced at STEP_HZ. Each debounced press of
//                btn_mode steps to the next animation.
//  Ports       : clk      - system clock (CLK_FREQ_HZ)
//                rst_n    - asynchronous active-low reset
//                btn_mode - raw asynchronous active-high mode button
//                led      - LED drive, active-high
//                mode     - current animation: 0 ALT, 1 CHASE, 2 BOUNCE,
//                           3 COUNT
//  Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 125_000_000,
    parameter int STEP_HZ     = 4,
    parameter int DEBOUNCE_MS = 20,
    parameter int NUM_LEDS    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                btn_mode,
    output logic [NUM_LEDS-1:0] led,
    output logic [1:0]          mode
);

    localparam int c_tick_div  = CLK_FREQ_HZ / STEP_HZ;
    localparam int c_db_cycles = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;
    localparam int c_tick_w    = cnt_width(c_tick_div);
    localparam int c_pos_w     = cnt_width(NUM_LEDS);

    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(c_tick_div - 1);
    localparam logic [c_pos_w-1:0]  c_pos_top   = c_pos_w'(NUM_LEDS - 1);

    logic                w_db_level;
    logic                w_db_rise;
    logic                w_mode_step;
    logic                w_tick;
    logic [NUM_LEDS-1:0] w_led;

    mode_t               r_mode;
    logic [c_tick_w-1:0] r_presc;
    logic                r_phase;
    logic [NUM_LEDS-1:0] r_chase;
    logic [c_pos_w-1:0]  r_pos;
    logic                r_dir_up;
    logic [NUM_LEDS-1:0] r_count;

    btn_debounce #(
        .DB_CYCLES (c_db_cycles)
    ) u_btn_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (btn_mode),
        .level (w_db_level),
        .rise  (w_db_rise)
    );

    // A rise can only occur while the settled level is still low; the
    // qualifier makes that explicit so a stray pulse can never double-step.
    assign w_mode_step = w_db_rise & ~w_db_level;
    assign w_tick      = (r_presc == c_tick_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode   <= MODE_ALT;
            r_presc  <= '0;
            r_phase  <= 1'b0;
            r_chase  <= NUM_LEDS'(1);
            r_pos    <= '0;
            r_dir_up <= 1'b1;
            r_count  <= '0;
        end else if (w_mode_step) begin
            // A mode change outranks a coincident tick: the tick is dropped
            // and every pattern restarts from its initial value.
            r_mode   <= mode_t'(r_mode + 2'd1);
            r_presc  <= '0;
            r_phase  <= 1'b0;
            r_chase  <= NUM_LEDS'(1);
            r_pos    <= '0;
            r_dir_up <= 1'b1;
            r_count  <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                case (r_mode)
                    MODE_ALT: begin
                        r_phase <= ~r_phase;
                    end
                    MODE_CHASE: begin
                        r_chase <= {r_chase[NUM_LEDS-2:0], r_chase[NUM_LEDS-1]};
                    end
                    MODE_BOUNCE: begin
                        // Turning at an end steps straight to the neighbour,
                        // so each endpoint is lit for a single tick per pass.
                        if (r_dir_up) begin
                            if (r_pos == c_pos_top) begin
                                r_pos    <= c_pos_top - 1'b1;
                                r_dir_up <= 1'b0;
                            end else begin
                                r_pos <= r_pos + 1'b1;
                            end
                        end else begin
                            if (r_pos == '0) begin
                                r_pos    <= c_pos_w'(1);
                                r_dir_up <= 1'b1;
                            end else begin
                                r_pos <= r_pos - 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_count <= r_count + 1'b1;
                    end
                endcase
            end
        end
    end

    always_comb begin
        w_led = '0;
        case (r_mode)
            MODE_ALT: begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    w_led[i] = (i % 2 == 1) ? r_phase : ~r_phase;
                end
            end
            MODE_CHASE:  w_led = r_chase;
            MODE_BOUNCE: w_led = NUM_LEDS'(1) << r_pos;
            default:     w_led = r_count;
        endcase
    end

    assign led  = w_led;
    assign mode = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_pattern_gen
//  Description : Self-checking bench for led_pattern_gen with a 10-clock step
//                and a 4-clock debounce window. The reference derives the
//                expected LEDs from the mode and the clocks elapsed since the
//                last restart, using closed-form pattern formulas.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_gen;

    localparam int c_tick_div = 10;
    localparam int c_db       = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_mode;
    logic [7:0] led;
    logic [1:0] mode;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: current mode, clocks since the last restart, the two
    // synchroniser samples, settled button level and its disagreement run.
    int   m_mode;
    int   m_el;
    int   m_run;
    logic m_db;
    logic m_sy0;
    logic m_sy1;

    led_pattern_gen #(
        .CLK_FREQ_HZ (1000),
        .STEP_HZ     (100),
        .DEBOUNCE_MS (4),
        .NUM_LEDS    (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_mode (btn_mode),
        .led      (led),
        .mode     (mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_led(input int m, input int el);
        int st;
        int k;
        st = el / c_tick_div;
        case (m)
            0:       return (st % 2 == 1) ? 8'hAA : 8'h55;
            1:       return 8'(1 << (st % 8));
            2: begin
                k = st % 14;
                return 8'(1 << ((k < 8) ? k : 14 - k));
            end
            default: return 8'(st % 256);
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_el   = 0;
        m_run  = 0;
        m_db   = 1'b0;
        m_sy0  = 1'b0;
        m_sy1  = 1'b0;
    endtask

    task automatic model_edge(input logic b);
        logic s2;
        bit   changed;
        changed = 1'b0;
        s2    = m_sy1;
        m_sy1 = m_sy0;
        m_sy0 = b;
        if (s2 != m_db) begin
            m_run++;
            if (m_run == c_db) begin
                m_db  = s2;
                m_run = 0;
                if (s2) begin
                    m_mode  = (m_mode + 1) % 4;
                    m_el    = 0;
                    changed = 1'b1;
                end
            end
        end else begin
            m_run = 0;
        end
        if (!changed) m_el++;
    endtask

    task automatic cycle(input logic b);
        btn_mode = b;
        @(posedge clk);
        if (rst_n) model_edge(b);
        #1;
        chk("led", led, exp_led(m_mode, m_el));
        chk("mode", mode, m_mode);
    endtask

    task automatic async_reset();
        btn_mode = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_led", led, 8'h55);
        chk("rst_mode", mode, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic press();
        repeat (6) cycle(1'b1);
        repeat (6) cycle(1'b0);
    endtask

    initial begin
        int   len;
        logic lvl;

        rst_n    = 1'b0;
        btn_mode = 1'b0;
        model_reset();
        repeat (3) cycle(1'b0);
        chk("reset_led", led, 8'h55);
        @(negedge clk);
        rst_n = 1'b1;

        // ALT from reset
        repeat (10) cycle(1'b0);
        chk("alt_10", led, 8'hAA);
        repeat (10) cycle(1'b0);
        chk("alt_20", led, 8'h55);

        // Short glitch rejected, long press accepted with fixed latency
        repeat (3) cycle(1'b1);
        repeat (20) cycle(1'b0);
        chk("reject3", mode, 0);
        repeat (5) cycle(1'b1);
        chk("lat_k4", mode, 0);
        cycle(1'b1);
        chk("lat_k5", mode, 1);
        repeat (4) cycle(1'b1);
        repeat (20) cycle(1'b0);
        chk("release", mode, 1);

        // CHASE through a wrap, BOUNCE through both ends, COUNT through wrap
        repeat (100) cycle(1'b0);
        press();
        chk("bounce_mode", mode, 2);
        repeat (160) cycle(1'b0);
        press();
        chk("count_mode", mode, 3);
        repeat (2600) cycle(1'b0);
        press();
        chk("alt_again", mode, 0);
        repeat (12) cycle(1'b0);

        // Random button activity with occasional asynchronous resets
        repeat (400) begin
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            repeat (len) cycle(lvl);
            if ($urandom_range(0, 49) == 0) async_reset();
        end

        // Mode change coinciding with a tick in CHASE at 0x04
        async_reset();
        press();
        repeat (18) cycle(1'b0);
        chk("pre_coll_led", led, 8'h04);
        repeat (5) cycle(1'b1);
        chk("pre_coll_mode", mode, 1);
        cycle(1'b1);
        chk("coll_mode", mode, 2);
        chk("coll_led", led, 8'h01);
        repeat (2) cycle(1'b1);
        repeat (7) cycle(1'b0);
        chk("coll_nostep", led, 8'h01);
        cycle(1'b0);
        chk("coll_step", led, 8'h02);

        // Reset in the middle of a debounce count
        repeat (3) cycle(1'b1);
        async_reset();
        repeat (3) cycle(1'b1);
        repeat (20) cycle(1'b0);
        chk("post_rst_reject", mode, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
